// File: rtl/fifo_prog_thresh_if.sv
// Handshake and status bundle for fifo_prog_thresh.
// Master drives requests/thresholds; slave (the FIFO) drives data and flags.
interface fifo_prog_thresh_if #(
    parameter int DATA_SIZE = 10,
    parameter int DEPTH     = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                 push;
    logic [DATA_SIZE-1:0] data_in;
    logic                 pop;
    logic [AW:0]          af_thresh;
    logic [AW:0]          ae_thresh;
    logic                 err_clr;
    logic [DATA_SIZE-1:0] data_out;
    logic                 data_valid;
    logic [AW:0]          count;
    logic                 empty;
    logic                 full;
    logic                 almost_empty;
    logic                 almost_full;
    logic                 pause;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output push, data_in, pop,
        output af_thresh, ae_thresh, err_clr,
        input  data_out, data_valid, count,
        input  empty, full, almost_empty, almost_full,
        input  pause, overflow, underflow
    );

    modport slave (
        input  push, data_in, pop,
        input  af_thresh, ae_thresh, err_clr,
        output data_out, data_valid, count,
        output empty, full, almost_empty, almost_full,
        output pause, overflow, underflow
    );
endinterface

// File: rtl/fifo_prog_thresh.sv
// Synchronous FIFO with programmable thresholds, hysteretic pause and error flags.
// Define FIFO_STICKY_ERR_EN to make overflow/underflow sticky until err_clr.
module fifo_prog_thresh #(
    parameter int DATA_SIZE = 10,
    parameter int DEPTH     = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    fifo_prog_thresh_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [AW:0]          count_q;
    logic [AW:0]          count_nxt;
    logic [DATA_SIZE-1:0] dout_q;
    logic                 valid_q;
    logic                 pause_q;
    logic                 pause_nxt;
    logic                 ovf_q;
    logic                 udf_q;
    logic                 ovf_nxt;
    logic                 udf_nxt;
    logic                 empty;
    logic                 full;
    logic                 pop_acc;
    logic                 push_acc;
    logic                 ovf_ev;
    logic                 udf_ev;
    logic                 pause_set;
    logic                 pause_clr;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign pop_acc  = bus.pop && !empty;
    // A pop on a full FIFO frees the slot the concurrent push lands in.
    assign push_acc = bus.push && (!full || pop_acc);
    assign ovf_ev   = bus.push && !push_acc;
    assign udf_ev   = bus.pop && empty;

    assign pause_set = (count_q >= bus.af_thresh);
    assign pause_clr = (count_q <= bus.ae_thresh);

    always_comb begin
        pause_nxt = pause_q;
        if (pause_set)
            pause_nxt = 1'b1;
        else if (pause_clr)
            pause_nxt = 1'b0;
    end

    always_comb begin
        count_nxt = count_q;
        if (push_acc && !pop_acc)
            count_nxt = count_q + CNT_ONE;
        else if (pop_acc && !push_acc)
            count_nxt = count_q - CNT_ONE;
    end

`ifdef FIFO_STICKY_ERR_EN
    assign ovf_nxt = ovf_ev || (ovf_q && !bus.err_clr);
    assign udf_nxt = udf_ev || (udf_q && !bus.err_clr);
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign ovf_nxt = ovf_ev;
    assign udf_nxt = udf_ev;
`endif

    always_ff @(posedge clk) begin
        if (reset && push_acc)
            mem[wptr] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            pause_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (push_acc)
                wptr <= wptr + PTR_ONE;
            if (pop_acc) begin
                rptr   <= rptr + PTR_ONE;
                dout_q <= mem[rptr];
            end
            count_q <= count_nxt;
            valid_q <= pop_acc;
            pause_q <= pause_nxt;
            ovf_q   <= ovf_nxt;
            udf_q   <= udf_nxt;
        end
    end

    assign bus.data_out     = dout_q;
    assign bus.data_valid   = valid_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = !empty && (count_q <= bus.ae_thresh);
    assign bus.almost_full  = pause_set;
    assign bus.pause        = pause_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_prog_thresh.sv
// Scoreboard bench for fifo_prog_thresh (DEPTH=8, DATA_SIZE=10).
// Honours FIFO_STICKY_ERR_EN for the error-flag model.
module tb_fifo_prog_thresh;
    logic clk;
    logic reset;
    logic [3:0] af;
    logic [3:0] ae;

    fifo_prog_thresh_if #(.DATA_SIZE(10), .DEPTH(8)) bus ();

    fifo_prog_thresh #(.DATA_SIZE(10), .DEPTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    assign bus.af_thresh = af;
    assign bus.ae_thresh = ae;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] mq[$];
    logic [9:0] exp_q[$];
    int   mcount;
    logic mpause;
    logic mvalid;
    logic movf;
    logic mudf;
    logic [9:0] exp_d;

    // Drive one cycle, advance the reference model, sample at posedge+1.
    task automatic drive(input logic p, input logic [9:0] d,
                         input logic po, input logic clr);
        logic pa;
        logic wa;
        bus.push    = p;
        bus.data_in = d;
        bus.pop     = po;
        bus.err_clr = clr;
        pa = po && (mcount != 0);
        wa = p && ((mcount != 8) || pa);
        if (!reset) begin
            mq.delete();
            exp_q.delete();
            mcount = 0;
            mpause = 0;
            mvalid = 0;
            movf   = 0;
            mudf   = 0;
        end else begin
            if (mcount >= int'(af))
                mpause = 1;
            else if (mcount <= int'(ae))
                mpause = 0;
            mvalid = pa;
            if (pa)
                exp_q.push_back(mq.pop_front());
            if (wa)
                mq.push_back(d);
            mcount = mcount + (wa ? 1 : 0) - (pa ? 1 : 0);
`ifdef FIFO_STICKY_ERR_EN
            movf = (p && !wa) || (movf && !clr);
            mudf = (po && mcount == 0 && !pa) || (mudf && !clr);
`else
            movf = p && !wa;
            mudf = po && !pa;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        af = 4'd6;
        ae = 4'd2;
        drive(0, 10'h0, 0, 0);
        drive(0, 10'h0, 0, 0);
        n_cmp++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 ||
            bus.full !== 1'b0 || bus.data_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: cnt=%0d e=%b f=%b v=%b need 0 1 0 0",
                     bus.count, bus.empty, bus.full, bus.data_valid);
        end
        n_cmp++;
        if (bus.pause !== 1'b0 || bus.overflow !== 1'b0 ||
            bus.underflow !== 1'b0 || bus.almost_empty !== 1'b0 ||
            bus.almost_full !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: p=%b o=%b u=%b ae=%b af=%b need 0",
                     bus.pause, bus.overflow, bus.underflow,
                     bus.almost_empty, bus.almost_full);
        end
        reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 10'(i), 0, 0);
            n_cmp++;
            if (bus.count !== 4'(mcount) || bus.pause !== mpause) begin
                n_bad++;
                $display("FAIL fill_cnt: cnt=%0d p=%b need %0d %b",
                         bus.count, bus.pause, mcount, mpause);
            end
        end
        n_cmp++;
        if (bus.full !== 1'b1 || bus.count !== 4'd8) begin
            n_bad++;
            $display("FAIL fill_full: f=%b cnt=%0d need 1 8",
                     bus.full, bus.count);
        end
        drive(1, 10'h3FF, 0, 0);
        n_cmp++;
        if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin
            n_bad++;
            $display("FAIL overflow: o=%b cnt=%0d need 1 8",
                     bus.overflow, bus.count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            drive(0, 10'h0, 1, 0);
            n_cmp++;
            if (bus.data_valid !== mvalid) begin
                n_bad++;
                $display("FAIL drain_valid: got %b need %b",
                         bus.data_valid, mvalid);
            end else if (mvalid) begin
                n_cmp++;
                exp_d = exp_q.pop_front();
                if (bus.data_out !== exp_d) begin
                    n_bad++;
                    $display("FAIL drain_data: got %h need %h",
                             bus.data_out, exp_d);
                end
            end
            n_cmp++;
            if (bus.overflow !== movf) begin
                n_bad++;
                $display("FAIL drain_ovf: got %b need %b",
                         bus.overflow, movf);
            end
        end
        n_cmp++;
        if (bus.empty !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_empty: got %b need 1", bus.empty);
        end
        drive(0, 10'h0, 1, 0);
        n_cmp++;
        if (bus.underflow !== 1'b1 || bus.data_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL underflow: u=%b v=%b need 1 0",
                     bus.underflow, bus.data_valid);
        end
    endtask

    task automatic test_pause();
        drive(0, 10'h0, 0, 1);
        n_cmp++;
        if (bus.overflow !== movf || bus.underflow !== mudf) begin
            n_bad++;
            $display("FAIL err_clr: o=%b u=%b need %b %b",
                     bus.overflow, bus.underflow, movf, mudf);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 10'h040 + 10'(i), 0, 0);
            n_cmp++;
            if (bus.pause !== mpause ||
                bus.almost_full !== (mcount >= int'(af)) ||
                bus.almost_empty !== (mcount != 0 && mcount <= int'(ae))) begin
                n_bad++;
                $display("FAIL fill_flags: p=%b af=%b ae=%b cnt=%0d",
                         bus.pause, bus.almost_full, bus.almost_empty, mcount);
            end
        end
        drive(0, 10'h0, 0, 0);
        n_cmp++;
        if (bus.pause !== 1'b1) begin
            n_bad++;
            $display("FAIL pause_set: got %b need 1", bus.pause);
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 10'h0, 1, 0);
            n_cmp++;
            if (bus.pause !== mpause || bus.data_valid !== mvalid) begin
                n_bad++;
                $display("FAIL drain_pause: p=%b v=%b need %b %b cnt=%0d",
                         bus.pause, bus.data_valid, mpause, mvalid, mcount);
            end else if (mvalid) begin
                n_cmp++;
                exp_d = exp_q.pop_front();
                if (bus.data_out !== exp_d) begin
                    n_bad++;
                    $display("FAIL pause_data: got %h need %h",
                             bus.data_out, exp_d);
                end
            end
            if (mcount == 3) begin
                drive(0, 10'h0, 0, 0);
                n_cmp++;
                if (bus.pause !== 1'b1) begin
                    n_bad++;
                    $display("FAIL pause_hold: got %b need 1", bus.pause);
                end
            end
            if (mcount == 2) begin
                drive(0, 10'h0, 0, 0);
                n_cmp++;
                if (bus.pause !== 1'b0) begin
                    n_bad++;
                    $display("FAIL pause_clr: got %b need 0", bus.pause);
                end
            end
        end
    endtask

    task automatic test_thresh();
        af = 4'd0;
        #1;
        n_cmp++;
        if (bus.almost_full !== 1'b1) begin
            n_bad++;
            $display("FAIL af_zero: got %b need 1", bus.almost_full);
        end
        drive(0, 10'h0, 0, 0);
        n_cmp++;
        if (bus.pause !== mpause || bus.pause !== 1'b1) begin
            n_bad++;
            $display("FAIL af_zero_pause: got %b need 1", bus.pause);
        end
        af = 4'd9;
        for (int i = 0; i < 8; i++) begin
            drive(1, 10'h100 + 10'(i), 0, 0);
            n_cmp++;
            if (bus.almost_full !== 1'b0 || bus.pause !== mpause) begin
                n_bad++;
                $display("FAIL af_off: af=%b p=%b need 0 %b",
                         bus.almost_full, bus.pause, mpause);
            end
        end
        af = 4'd6;
    endtask

    task automatic test_full_pushpop();
        drive(1, 10'h0AA, 1, 0);
        n_cmp++;
        if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL full_pp: cnt=%0d o=%b need 8 0",
                     bus.count, bus.overflow);
        end
        for (int i = 0; i < 9; i++) begin
            if (i > 0)
                drive(0, 10'h0, 1, 0);
            n_cmp++;
            exp_d = exp_q.pop_front();
            if (bus.data_valid !== 1'b1 || bus.data_out !== exp_d) begin
                n_bad++;
                $display("FAIL full_pp_data: v=%b got %h need %h",
                         bus.data_valid, bus.data_out, exp_d);
            end
        end
        n_cmp++;
        if (bus.data_out !== 10'h0AA || bus.empty !== 1'b1) begin
            n_bad++;
            $display("FAIL full_pp_last: got %h e=%b need 0aa 1",
                     bus.data_out, bus.empty);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++)
            drive(1, 10'h200 + 10'(i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 10'(($urandom & 32'h3FF)), 1, 0);
            n_cmp++;
            exp_d = exp_q.pop_front();
            if (bus.data_valid !== 1'b1 || bus.data_out !== exp_d ||
                bus.count !== 4'd5) begin
                n_bad++;
                $display("FAIL wrap: v=%b got %h need %h cnt=%0d",
                         bus.data_valid, bus.data_out, exp_d, bus.count);
            end
        end
    endtask

    task automatic test_mid_reset();
        af = 4'd4;
        drive(0, 10'h0, 0, 0);
        n_cmp++;
        if (bus.pause !== 1'b1 || bus.count !== 4'd5) begin
            n_bad++;
            $display("FAIL pre_reset: p=%b cnt=%0d need 1 5",
                     bus.pause, bus.count);
        end
        reset = 1'b0;
        drive(0, 10'h0, 0, 0);
        reset = 1'b1;
        n_cmp++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 ||
            bus.pause !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: cnt=%0d e=%b p=%b need 0 1 0",
                     bus.count, bus.empty, bus.pause);
        end
        drive(0, 10'h0, 1, 0);
        n_cmp++;
        if (bus.underflow !== 1'b1 || bus.data_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_pop: u=%b v=%b need 1 0",
                     bus.underflow, bus.data_valid);
        end
        drive(0, 10'h0, 0, 0);
        n_cmp++;
        if (bus.underflow !== mudf) begin
            n_bad++;
            $display("FAIL udf_hold: got %b need %b", bus.underflow, mudf);
        end
        drive(0, 10'h0, 0, 1);
        n_cmp++;
        if (bus.underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL udf_clear: got %b need 0", bus.underflow);
        end
    endtask

    initial begin
        bus.push    = 1'b0;
        bus.data_in = '0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
        mcount = 0;
        mpause = 0;
        mvalid = 0;
        movf   = 0;
        mudf   = 0;
        test_reset();
        test_fill();
        test_drain();
        test_pause();
        test_thresh();
        test_full_pushpop();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
